// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and
// release, and emits one fixed-width kbEN strobe per physical key press with
// the bit-reversed key index on pressedkey.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int STROBE_LEN      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       kbEN,
  output logic [3:0] pressedkey
);

  // One shared counter serves row dwell, both debounce phases and the strobe,
  // so it is sized for the largest of the three limits.
  localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_P  = (MAX_AB > STROBE_LEN) ? MAX_AB : STROBE_LEN;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_LEN - 1);

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_EMIT,
    ST_STROBE,
    ST_HOLD,
    ST_DEB_REL
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       row_reg, row_next;
  logic [1:0]       col_reg, col_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       key_reg, key_next;
  logic [3:0]       row_out_reg;
  logic             kb_en_reg;

  // Two-stage synchroniser for the asynchronous column inputs.
  logic [3:0] col_meta_reg;
  logic [3:0] col_s;

  // Single-low column decode and key code lookup.
  logic       one_low;
  logic [1:0] low_col;
  logic [3:0] cand_pattern;
  logic [3:0] key_index;
  logic [3:0] key_code;

  // Synchronise col_in; idle (all released) value on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_reg <= 4'b1111;
      col_s        <= 4'b1111;
    end else begin
      col_meta_reg <= col_in;
      col_s        <= col_meta_reg;
    end
  end

  // Accept a row only when exactly one column reads low; multi-key is rejected.
  always_comb begin
    one_low = 1'b1;
    low_col = 2'd0;
    case (col_s)
      4'b1110: low_col = 2'd0;
      4'b1101: low_col = 2'd1;
      4'b1011: low_col = 2'd2;
      4'b0111: low_col = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Column pattern expected while the latched candidate is held down.
  assign cand_pattern = ~(4'b0001 << col_reg);

  // Keypad legend to key index (digits = value, '='=10, AC=11, + - * / = 12..15).
  always_comb begin
    key_index = 4'd0;
    case ({row_reg, col_reg})
      4'b00_00: key_index = 4'd1;
      4'b00_01: key_index = 4'd2;
      4'b00_10: key_index = 4'd3;
      4'b00_11: key_index = 4'd12;
      4'b01_00: key_index = 4'd4;
      4'b01_01: key_index = 4'd5;
      4'b01_10: key_index = 4'd6;
      4'b01_11: key_index = 4'd13;
      4'b10_00: key_index = 4'd7;
      4'b10_01: key_index = 4'd8;
      4'b10_10: key_index = 4'd9;
      4'b10_11: key_index = 4'd14;
      4'b11_00: key_index = 4'd11;
      4'b11_01: key_index = 4'd0;
      4'b11_10: key_index = 4'd10;
      4'b11_11: key_index = 4'd15;
      default:  key_index = 4'd0;
    endcase
  end

  // The consumer expects the index bit-reversed.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bitrev
      assign key_code[gi] = key_index[3-gi];
    end
  endgenerate

  // State, counters, latched candidate, and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_SCAN;
      row_reg     <= 2'd0;
      col_reg     <= 2'd0;
      cnt_reg     <= '0;
      key_reg     <= 4'b0000;
      row_out_reg <= 4'b1110;
      kb_en_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      cnt_reg     <= cnt_next;
      key_reg     <= key_next;
      row_out_reg <= ~(4'b0001 << row_next);
      kb_en_reg   <= (state_next == ST_STROBE);
    end
  end

  // Next-state logic: scan, debounce press, emit, strobe, hold, debounce release.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    cnt_next   = cnt_reg;
    key_next   = key_reg;
    case (state_reg)
      ST_SCAN: begin
        if (cnt_reg == SCAN_LAST) begin
          cnt_next = '0;
          if (one_low) begin
            // Row stays driven while the candidate is debounced.
            col_next   = low_col;
            state_next = ST_DEB_PRESS;
          end else begin
            row_next = row_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        if (col_s != cand_pattern) begin
          // Bounce or change of key: drop the candidate and keep scanning.
          state_next = ST_SCAN;
          row_next   = row_reg + 2'd1;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          // Code is loaded here so it is visible a cycle before kbEN rises.
          state_next = ST_EMIT;
          cnt_next   = '0;
          key_next   = key_code;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_EMIT: begin
        state_next = ST_STROBE;
        cnt_next   = '0;
      end
      ST_STROBE: begin
        if (cnt_reg == STROBE_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (col_s == 4'b1111) begin
          state_next = ST_DEB_REL;
          cnt_next   = '0;
        end
      end
      ST_DEB_REL: begin
        if (col_s != 4'b1111) begin
          // Any low column restarts the release window; no new event.
          cnt_next = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = ST_SCAN;
          row_next   = 2'd0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_SCAN;
        row_next   = 2'd0;
        cnt_next   = '0;
      end
    endcase
  end

  assign row_out    = row_out_reg;
  assign kbEN       = kb_en_reg;
  assign pressedkey = key_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed key scenarios against a keypad model, with an
// event scoreboard that checks strobe width, code stability and event order.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int STRB     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       kbEN;
  logic [3:0] pressedkey;

  // pressed[r*4+c] = key at row r, column c is held down.
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .STROBE_LEN(STRB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_out(row_out),
    .kbEN(kbEN),
    .pressedkey(pressedkey)
  );

  // Keypad: a pressed key ties its column to its row drive.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input int idx, input logic [3:0] code, input int hold, input int rel);
    exp_q.push_back(code);
    pressed[idx] = 1'b1;
    wait_cycles(hold);
    pressed = '0;
    wait_cycles(rel);
    check("missing_events", exp_q.size(), 0);
    $display("event idx %0d expected code %b done", idx, code);
  endtask

  // Scoreboard: every kbEN rise must match the next expected code, the code
  // must be settled a cycle earlier, stay stable, and the pulse be STRB wide.
  initial begin : compare
    logic       prev_kb;
    logic [3:0] prev_pk;
    logic [3:0] rise_pk;
    int         width;
    prev_kb = 1'b0;
    prev_pk = 4'b0000;
    rise_pk = 4'b0000;
    width   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_kb = 1'b0;
        prev_pk = 4'b0000;
        width   = 0;
      end else begin
        check("row_onehot_low", $countones(~row_out), 1);
        if (pressedkey !== prev_pk && !kbEN) begin
          if (exp_q.size() == 0) check("unexpected_code_change", pressedkey, prev_pk);
          else check("code_loaded", pressedkey, exp_q[0]);
        end
        if (kbEN && !prev_kb) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", kbEN, 1'b0);
          end else begin
            check("event_code", pressedkey, exp_q[0]);
            exp_q.delete(0);
          end
          check("code_settled_before_strobe", pressedkey, prev_pk);
          rise_pk = pressedkey;
          width   = 1;
        end else if (kbEN) begin
          width++;
          check("code_stable_in_strobe", pressedkey, rise_pk);
        end
        if (!kbEN && prev_kb) check("strobe_width", width, STRB);
        prev_kb = kbEN;
        prev_pk = pressedkey;
      end
    end
  end

  initial begin : stim
    int  kb_high;
    bit  seen;

    // Reset state.
    wait_cycles(3);
    check("reset_row_out", row_out, 4'b1110);
    check("reset_kbEN", kbEN, 1'b0);
    check("reset_pressedkey", pressedkey, 4'b0000);

    // Key 5 held from reset release: exact latency pinned by hand.
    exp_q.push_back(4'b1010);
    pressed[5] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 16) begin
        check("t16_pressedkey", pressedkey, 4'b1010);
        check("t16_kbEN_low", kbEN, 1'b0);
      end
      if (cyc == 17) check("t17_kbEN_high", kbEN, 1'b1);
      if (cyc == 18) check("t18_kbEN_high", kbEN, 1'b1);
      if (cyc == 19) check("t19_kbEN_low", kbEN, 1'b0);
    end
    pressed = '0;
    wait_cycles(40);
    check("missing_events", exp_q.size(), 0);
    $display("event key 5 expected code 1010 done");

    // Sequence 1, +, 2, = with full releases.
    press_release(0,  4'b1000, 80, 40);
    press_release(3,  4'b0011, 80, 40);
    press_release(1,  4'b0100, 80, 40);
    press_release(14, 4'b0101, 80, 40);

    // AC with a low-high-low bounce before settling.
    exp_q.push_back(4'b1101);
    pressed[12] = 1'b1; @(negedge clk); check("bounce_no_kbEN", kbEN, 1'b0);
    pressed[12] = 1'b0; @(negedge clk); check("bounce_no_kbEN", kbEN, 1'b0);
    pressed[12] = 1'b1; @(negedge clk); check("bounce_no_kbEN", kbEN, 1'b0);
    wait_cycles(80);
    pressed = '0;
    wait_cycles(40);
    check("missing_events", exp_q.size(), 0);
    $display("event AC with bounce expected code 1101 done");

    // 4 and 6 together: rejected; releasing 6 leaves 4.
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    kb_high = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (kbEN) kb_high++;
    end
    check("multikey_no_event", kb_high, 0);
    exp_q.push_back(4'b0010);
    pressed[6] = 1'b0;
    wait_cycles(80);
    pressed = '0;
    wait_cycles(40);
    check("missing_events", exp_q.size(), 0);
    $display("event 4 after multikey expected code 0010 done");

    // '/' held 200 cycles with 2-cycle release glitches every 50.
    exp_q.push_back(4'b1111);
    for (int k = 1; k <= 200; k++) begin
      pressed[15] = !((k >= 50) && ((k % 50) < 2));
      @(negedge clk);
    end
    pressed = '0;
    wait_cycles(40);
    check("missing_events", exp_q.size(), 0);
    $display("event / with glitches expected code 1111 done");
    press_release(13, 4'b0000, 80, 40);

    // Reset during the strobe, '/' still held afterwards.
    exp_q.push_back(4'b1111);
    pressed[15] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (kbEN) seen = 1'b1;
    end
    check("strobe_seen_before_reset", seen, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midstrobe_reset_kbEN", kbEN, 1'b0);
    check("midstrobe_reset_pressedkey", pressedkey, 4'b0000);
    check("midstrobe_reset_row_out", row_out, 4'b1110);
    wait_cycles(2);
    exp_q.push_back(4'b1111);
    reset = 1'b0;
    wait_cycles(80);
    pressed = '0;
    wait_cycles(40);
    check("missing_events", exp_q.size(), 0);
    $display("event / after reset expected code 1111 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad and produces debounced key events for the calculator control FSB.
- Output is a one-shot `kbEN` strobe with a stable 4-bit `pressedkey` code.
- This block is the producing end of the `kbEN`/`pressedkey` interface that the calculator state machine consumes on the rising edge of `kbEN`.
- It has no autorepeat: exactly one event per physical press.

Parameters:
SCAN_DIV, 1000, clk cycles each row is driven before moving on (>=3)
DEBOUNCE_CYCLES, 20000, consecutive stable cycles required for press and for release (>=2)
STROBE_LEN, 4, clk cycles `kbEN` stays high per event (>=1)

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high reset
col_in  input  4  keypad columns, active low (pulled up), asynchronous to clk
row_out  output  4  keypad row drive, one-hot active low
kbEN  output  1  key event strobe; consumer samples `pressedkey` on its rising edge
pressedkey  output  4  key code of the most recent event

Behaviour:
- Key index layout (row r = 0..3, col c = 0..3):
  - row0: 1, 2, 3, +
  - row1: 4, 5, 6, -
  - row2: 7, 8, 9, *
  - row3: AC, 0, =, /
- Index values: digits = their value; = is 10; AC is 11; + is 12; - is 13; * is 14; / is 15.
- `pressedkey` = bit-reverse of the index. Examples: 5 -> 1010, 0 -> 0000, = -> 0101, AC -> 1101, + -> 0011, - -> 1011, * -> 0111, / -> 1111.
- Synchronisation: `col_in` passes through a 2-flop synchroniser; all decisions use the synchronised value `col_s`.
- Reset values (asserted asynchronously, immediately): `row_out` = 1110, `kbEN` = 0, `pressedkey` = 0000, state SCAN, row 0, all counters 0.
- SCAN:
  - Drive row r (row_out bit r low, others high) for SCAN_DIV cycles.
  - On the last dwell cycle, if `col_s` has exactly one 0 bit at column c: latch candidate (r,c), go to DEB_PRESS, and keep row r driven.
  - Otherwise advance to row (r+1) mod 4 (row 3 wraps to row 0).
  - Zero or more than one column low in the row: no candidate (multi-key rejected).
- DEB_PRESS:
  - Counts cycles in which `col_s` equals the candidate pattern.
  - Any mismatching cycle: abandon the candidate, return to SCAN at row (r+1) mod 4, and clear the counter.
  - After DEBOUNCE_CYCLES matching cycles, go to EMIT.
- EMIT (1 cycle): load `pressedkey` with the candidate code; `kbEN` stays 0.
- STROBE: `kbEN` = 1 for exactly STROBE_LEN cycles; `pressedkey` is stable throughout.
- HOLD: row r stays driven; wait for `col_s` = 1111.
- DEB_REL:
  - Needs DEBOUNCE_CYCLES consecutive cycles of `col_s` = 1111.
  - Any low column restarts the count (stays in DEB_REL, no new event).
  - On completion, go to SCAN at row 0.
- Timing: candidate detected at cycle T → `pressedkey` updated at T+DEBOUNCE_CYCLES+1 → `kbEN` high from T+DEBOUNCE_CYCLES+2 for STROBE_LEN cycles. `pressedkey` therefore changes at least one cycle before `kbEN` rises.
- `pressedkey` holds its value between events; it changes only in EMIT.
- Keys pressed during STROBE, HOLD or DEB_REL (other rows/cols) are ignored. A new event needs a full release first.
- Reset mid-debounce or mid-strobe: `kbEN` drops at once and no event is emitted. After reset deasserts, a still-held key is detected afresh in scanning, so it produces one event.
- Counter widths: sized for the largest parameter. Counters saturate/clear as stated and never wrap into a false event.

Test Plan:
(All with SCAN_DIV=4, DEBOUNCE_CYCLES=8, STROBE_LEN=2; keypad model connects a pressed key's column to its row drive.)
- Press 5 (row1,col1), hold 100 cycles, release → exactly one `kbEN` pulse 2 cycles wide; `pressedkey` = 1010 at its rising edge.
- Sequence 1, +, 2, = with full releases between → codes 1000, 0011, 0100, 0101 in order, four pulses.
- Press AC with a 3-cycle bounce (low, high, low) before settling → no pulse during the bounce; one pulse with 1101 once stable 8 cycles.
- Press 4 and 6 together (same row) → no `kbEN` ever. Release 6 while holding 4 → one pulse with 0010.
- Hold / for 200 cycles with 2-cycle release glitches every 50 cycles → single pulse 1111, no repeats; after clean release, press 0 → 0000.
- Assert reset during STROBE → `kbEN` = 0, `pressedkey` = 0000, `row_out` = 1110 immediately. With / still held after deassert → one new event 1111.
